bu2_ifft: RTL and testbench
===========================

Name: bu2_ifft

Overview:
- Gentleman-Sande inverse-NTT butterfly; the decode-direction counterpart of the forward Cooley-Tukey butterfly BU2_FFT.
- Per accepted pair it computes a' = (in1 + in2) mod q and b' = ((in1 − in2) · twiddle) mod q.
- Optional halving of both results implements the 1/2 scaling per INTT stage.
- Sits in the INTT datapath after the memory read stage; twiddle and modulus are forwarded with the results so stages can be cascaded.

Parameters:
- DATA_W, `D_width, width of coefficients, twiddle and modulus.
- LATENCY, 3, fixed pipeline depth. Informational only; the RTL is not configurable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  the input operands are valid this cycle.
- in1  input  DATA_W  upper coefficient; must be < modulus.
- in2  input  DATA_W  lower coefficient; must be < modulus.
- twiddle  input  DATA_W  inverse twiddle factor; must be < modulus.
- modulus  input  DATA_W  q; must be odd and ≥ 3; sampled per pair.
- scale_en  input  1  when 1, both results are multiplied by 2⁻¹ mod q.
- BU_valid  output  1  outputs are valid this cycle.
- ifft_a  output  DATA_W  a' result.
- ifft_b  output  DATA_W  b' result.
- twiddle_BU_out  output  DATA_W  twiddle aligned with the results.
- modulus_BU_out  output  DATA_W  modulus aligned with the results.

Behaviour:
- Reset:
  - While rst = 0, all pipeline registers and valid bits clear asynchronously.
  - BU_valid = 0; ifft_a, ifft_b, twiddle_BU_out and modulus_BU_out = 0.
  - Reset asserted mid-operation discards every in-flight pair; no partial output appears after release.
  - First accept is on the first rising edge with rst = 1.
- Throughput and latency:
  - Fully pipelined, no backpressure; one pair accepted per cycle whenever in_valid = 1.
  - A pair accepted at edge N appears with BU_valid = 1 after edge N+3.
  - Gaps in in_valid propagate as gaps in BU_valid; order is preserved.
- Stage 1 (edge N):
  - Register sum = in1 + in2 (DATA_W+1 bits); subtract q if sum ≥ q.
  - Register diff = in1 − in2; add q if in1 < in2.
  - Register twiddle, modulus, scale_en and the valid bit.
- Stage 2 (edge N+1):
  - Register prod = diff · twiddle at full 2·DATA_W width.
  - Register a_h = scale_en ? half(sum) : sum.
  - half(x) = x[0] ? (x + q) >> 1 : x >> 1, computed at DATA_W+1 bits so it cannot overflow.
- Stage 3 (edge N+2, visible after N+3):
  - r = prod mod q.
  - ifft_b = scale_en ? half(r) : r.
  - ifft_a = a_h.
  - twiddle_BU_out and modulus_BU_out carry the stage-2 copies.
- Every output result lies in [0, q−1]. No wrap at the DATA_W boundary is permitted.
- When BU_valid = 0, data outputs hold their last value; the bench must not check them.
- Modulus may change per pair; each pair uses its own pipelined copy.
- Out-of-range inputs (≥ q) are illegal. Output is undefined but must not hang the pipeline or corrupt adjacent pairs.

Test Plan:
- Reset and basic pair:
  - Stimulus: reset asserted → all outputs 0, BU_valid 0.
  - Then q=193, in1=10, in2=5, w=3, scale_en=0 → BU_valid at edge+3, ifft_a=15, ifft_b=15.
  - Same pair with scale_en=1 → ifft_a=104, ifft_b=104.
- Wrap cases, q=193:
  - in1=5, in2=10, w=1 → a=15, b=188.
  - in1=150, in2=100, w=2 → a=57, b=100.
  - in1=192, in2=192, w=192 → a=191, b=0.
  - in1=0, in2=192, w=192 → a=192, b=192.
- Round trip:
  - Forward butterfly of x=10, y=5, w=3 gives A=25, B=188.
  - Feed A, B with w⁻¹=129 and scale_en=1 → ifft_a=10, ifft_b=5.
- Streaming:
  - 96 back-to-back valid pairs → 96 consecutive BU_valid cycles, in order.
  - Results must match the golden fft_up/fft_down pattern files run in reverse.
- Bubbles and reset mid-stream:
  - Stimulus: in_valid pattern 1,0,1,1,0 → BU_valid follows the same pattern 3 cycles later.
  - Assert rst with 2 pairs in flight → BU_valid drops immediately; no stale outputs after release.

Source files
------------

// File: rtl/bu2_ifft_if.sv
// Streaming port bundle for the bu2_ifft inverse-NTT butterfly: operands in,
// results plus forwarded twiddle/modulus out.
interface bu2_ifft_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] twiddle;
    logic [DATA_W-1:0] modulus;
    logic              scale_en;

    logic              BU_valid;
    logic [DATA_W-1:0] ifft_a;
    logic [DATA_W-1:0] ifft_b;
    logic [DATA_W-1:0] twiddle_BU_out;
    logic [DATA_W-1:0] modulus_BU_out;

    modport master (
        output in_valid, in1, in2, twiddle, modulus, scale_en,
        input  BU_valid, ifft_a, ifft_b, twiddle_BU_out, modulus_BU_out
    );

    modport slave (
        input  in_valid, in1, in2, twiddle, modulus, scale_en,
        output BU_valid, ifft_a, ifft_b, twiddle_BU_out, modulus_BU_out
    );
endinterface

// File: rtl/bu2_ifft.sv
// Gentleman-Sande inverse-NTT butterfly: a' = (in1+in2) mod q, b' = ((in1-in2)*w) mod q,
// with optional halving mod q. Fixed 3-cycle latency, one pair per cycle, no backpressure.
module bu2_ifft #(
    parameter int DATA_W = 16
) (
    input logic         clk,
    input logic         rst,
    bu2_ifft_if.slave   bus
);

    // x/2 mod q for odd q: an odd x becomes even by adding q; one extra bit prevents overflow.
    function automatic logic [DATA_W-1:0] half(input logic [DATA_W:0]   x,
                                               input logic [DATA_W-1:0] q);
        logic [DATA_W:0] t;
        t = x[0] ? x + {1'b0, q} : x;
        return DATA_W'(t >> 1);
    endfunction

    // Stage 1 combinational: modular add and subtract of the incoming pair.
    logic [DATA_W:0]   sum_full;
    logic [DATA_W:0]   sum_red;
    logic [DATA_W-1:0] diff_red;

    always_comb begin
        sum_full = {1'b0, bus.in1} + {1'b0, bus.in2};
        sum_red  = (sum_full >= {1'b0, bus.modulus}) ? sum_full - {1'b0, bus.modulus} : sum_full;
        diff_red = bus.in1 - bus.in2 + ((bus.in1 < bus.in2) ? bus.modulus : '0);
    end

    logic                v1, v2, v3, out_valid;
    logic                sc1, sc2, sc3;
    logic [DATA_W-1:0]   sum1, diff1, tw1, mod1;
    logic [DATA_W-1:0]   a2, tw2, mod2;
    logic [2*DATA_W-1:0] prod2;
    logic [DATA_W-1:0]   a3, r3, tw3, mod3;
    logic [DATA_W-1:0]   out_a, out_b, out_tw, out_mod;

    // NOTE: every pipeline register, data included, clears on reset so the
    // outputs read 0 and no stale pair can surface after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;  v2    <= 1'b0;  v3   <= 1'b0;
            sc1   <= 1'b0;  sc2   <= 1'b0;  sc3  <= 1'b0;
            sum1  <= '0;    diff1 <= '0;    tw1  <= '0;  mod1 <= '0;
            a2    <= '0;    prod2 <= '0;    tw2  <= '0;  mod2 <= '0;
            a3    <= '0;    r3    <= '0;    tw3  <= '0;  mod3 <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage read the previous
            // stage's old value, which is what keeps the pairs from mixing.
            v1    <= bus.in_valid;
            sc1   <= bus.scale_en;
            sum1  <= DATA_W'(sum_red);
            diff1 <= diff_red;
            tw1   <= bus.twiddle;
            mod1  <= bus.modulus;

            v2    <= v1;
            sc2   <= sc1;
            prod2 <= {{DATA_W{1'b0}}, diff1} * {{DATA_W{1'b0}}, tw1};
            a2    <= sc1 ? half({1'b0, sum1}, mod1) : sum1;
            tw2   <= tw1;
            mod2  <= mod1;

            v3    <= v2;
            sc3   <= sc2;
            r3    <= (mod2 == '0) ? '0 : DATA_W'(prod2 % {{DATA_W{1'b0}}, mod2});
            a3    <= a2;
            tw3   <= tw2;
            mod3  <= mod2;
        end
    end

    // Output register: data holds its last value through bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_tw    <= '0;
            out_mod   <= '0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                out_a   <= a3;
                out_b   <= sc3 ? half({1'b0, r3}, mod3) : r3;
                out_tw  <= tw3;
                out_mod <= mod3;
            end
        end
    end

    assign bus.BU_valid       = out_valid;
    assign bus.ifft_a         = out_a;
    assign bus.ifft_b         = out_b;
    assign bus.twiddle_BU_out = out_tw;
    assign bus.modulus_BU_out = out_mod;

endmodule

// File: tb/tb_bu2_ifft.sv
// Self-checking bench for bu2_ifft: directed spec vectors, bubbles, mid-stream reset
// and a random stream, all scored against a plain-arithmetic modular model.
module tb_bu2_ifft;

    localparam int DATA_W = 16;
    localparam int HIST   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bu2_ifft_if #(.DATA_W(DATA_W)) bus ();

    bu2_ifft #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // What was accepted at each post-reset edge, and what the results must be.
    bit     hist_v  [HIST];
    longint hist_a  [HIST];
    longint hist_b  [HIST];
    longint hist_tw [HIST];
    longint hist_q  [HIST];
    int     edge_n = 0;

    function automatic longint inv2_mul(input longint x, input longint q, input bit sc);
        return sc ? (x * ((q + 1) / 2)) % q : x;
    endfunction

    function automatic longint model_a(input longint x, input longint y, input longint q, input bit sc);
        return inv2_mul((x + y) % q, q, sc);
    endfunction

    function automatic longint model_b(input longint x, input longint y, input longint w,
                                       input longint q, input bit sc);
        return inv2_mul((((x - y + q) % q) * w) % q, q, sc);
    endfunction

    // Drive one cycle's inputs (away from the edge), take the edge, then score outputs.
    // ea/eb < 0 means "use the model"; otherwise they are hand-derived expectations.
    task automatic cycle(input bit v, input longint x, input longint y, input longint w,
                         input longint q, input bit sc, input longint ea, input longint eb);
        bus.in_valid = v;
        bus.in1      = DATA_W'(x);
        bus.in2      = DATA_W'(y);
        bus.twiddle  = DATA_W'(w);
        bus.modulus  = DATA_W'(q);
        bus.scale_en = sc;
        @(posedge clk);
        edge_n++;
        hist_v[edge_n]  = v;
        hist_tw[edge_n] = w;
        hist_q[edge_n]  = q;
        hist_a[edge_n]  = (ea >= 0) ? ea : (v ? model_a(x, y, q, sc) : 0);
        hist_b[edge_n]  = (eb >= 0) ? eb : (v ? model_b(x, y, w, q, sc) : 0);
        #1;
        if (edge_n >= 3) begin
            check("BU_valid", longint'(bus.BU_valid), longint'(hist_v[edge_n-3]));
            if (hist_v[edge_n-3]) begin
                check("ifft_a",  longint'(bus.ifft_a),         hist_a[edge_n-3]);
                check("ifft_b",  longint'(bus.ifft_b),         hist_b[edge_n-3]);
                check("twiddle", longint'(bus.twiddle_BU_out), hist_tw[edge_n-3]);
                check("modulus", longint'(bus.modulus_BU_out), hist_q[edge_n-3]);
            end
        end else begin
            check("BU_valid_early", longint'(bus.BU_valid), 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 193, 1'b0, -1, -1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"},   longint'(bus.BU_valid),       0);
        check({tag, "_a"},       longint'(bus.ifft_a),         0);
        check({tag, "_b"},       longint'(bus.ifft_b),         0);
        check({tag, "_twiddle"}, longint'(bus.twiddle_BU_out), 0);
        check({tag, "_modulus"}, longint'(bus.modulus_BU_out), 0);
    endtask

    // Directed vectors: x, y, w, q, scale, expected a, expected b.
    typedef struct {
        longint x, y, w, q;
        bit     sc;
        longint ea, eb;
    } vec_t;

    vec_t directed [8] = '{
        '{10,  5,   3,   193, 1'b0, 15,  15 },
        '{10,  5,   3,   193, 1'b1, 104, 104},
        '{5,   10,  1,   193, 1'b0, 15,  188},
        '{150, 100, 2,   193, 1'b0, 57,  100},
        '{192, 192, 192, 193, 1'b0, 191, 0  },
        '{0,   192, 192, 193, 1'b0, 192, 192},
        '{25,  188, 129, 193, 1'b1, 10,  5  },
        '{0,   0,   0,   3,   1'b1, 0,   0  }
    };

    initial begin
        longint q, x, y, w;
        bus.in_valid = 1'b0;
        bus.in1      = '0;
        bus.in2      = '0;
        bus.twiddle  = '0;
        bus.modulus  = '0;
        bus.scale_en = 1'b0;
        foreach (hist_v[i]) hist_v[i] = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b1;

        // Directed pairs, back to back.
        foreach (directed[i])
            cycle(1'b1, directed[i].x, directed[i].y, directed[i].w, directed[i].q,
                  directed[i].sc, directed[i].ea, directed[i].eb);
        idle(4);

        // Bubble pattern 1,0,1,1,0.
        cycle(1'b1, 10, 5, 3, 193, 1'b0, -1, -1);
        cycle(1'b0, 0, 0, 0, 193, 1'b0, -1, -1);
        cycle(1'b1, 150, 100, 2, 193, 1'b1, -1, -1);
        cycle(1'b1, 0, 192, 192, 193, 1'b0, -1, -1);
        cycle(1'b0, 0, 0, 0, 193, 1'b0, -1, -1);
        idle(4);

        // Reset with two pairs in flight: valid drops at once, nothing stale after release.
        cycle(1'b1, 7, 9, 11, 193, 1'b0, -1, -1);
        cycle(1'b1, 8, 2, 5, 193, 1'b1, -1, -1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_cleared("midreset");
        foreach (hist_v[i]) hist_v[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(5);

        // 96 back-to-back random pairs, modulus changing per pair.
        for (int i = 0; i < 96; i++) begin
            q = longint'($urandom_range(3, 65535) | 1);
            x = longint'($urandom) % q;
            y = longint'($urandom) % q;
            w = longint'($urandom) % q;
            cycle(1'b1, x, y, w, q, 1'($urandom), -1, -1);
        end

        // Random traffic with random gaps.
        for (int i = 0; i < 120; i++) begin
            q = longint'($urandom_range(3, 65535) | 1);
            x = longint'($urandom) % q;
            y = longint'($urandom) % q;
            w = longint'($urandom) % q;
            cycle(1'($urandom), x, y, w, q, 1'($urandom), -1, -1);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
